// File: rtl/div_tc_pkg.sv
// Shared types and constants for the sequential two's-complement divider.
// abs_u returns a two's-complement magnitude as an unsigned value.
package div_tc_pkg;

   localparam int DIV_DW   = 32;
   localparam int DIV_VW   = 16;
   localparam int DIV_RW   = 18;
   localparam int DIV_ITER = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_FIX,
      ST_DONE
   } div_state_t;

   // The most negative input maps to 0x8000_0000, which is still the correct unsigned magnitude.
   function automatic logic [DIV_DW-1:0] abs_u(input logic [DIV_DW-1:0] v);
      return v[DIV_DW-1] ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/div_nr_step.sv
// One non-restoring division iteration: shift in the next dividend bit, then add or subtract D.
// The add/subtract uses a 4-bit-group carry-lookahead adder.
module div_nr_step
   import div_tc_pkg::*;
(
   input  logic signed [DIV_RW-1:0] r_in,
   input  logic        [DIV_VW-1:0] d_in,
   input  logic                     bit_in,
   output logic signed [DIV_RW-1:0] r_out,
   output logic                     q_bit
);

   localparam int GS = 4;
   localparam int NG = (DIV_RW + GS - 1) / GS;

   logic              sub;
   logic [DIV_RW-1:0] a_op;
   logic [DIV_RW-1:0] b_op;
   logic [DIV_RW-1:0] sum;

   assign sub  = ~r_in[DIV_RW-1];
   assign a_op = {r_in[DIV_RW-2:0], bit_in};
   assign b_op = sub ? ~{2'b00, d_in} : {2'b00, d_in};

   // Group generate/propagate feed the inter-group carries; the top group has no carry-out consumer.
   always_comb begin : cla
      logic [DIV_RW-2:0] g;
      logic [DIV_RW-1:0] p;
      logic [DIV_RW-1:0] c_bit;
      logic [NG-2:0]     grp_g;
      logic [NG-2:0]     grp_p;
      logic [NG-1:0]     cg;
      g     = a_op[DIV_RW-2:0] & b_op[DIV_RW-2:0];
      p     = a_op ^ b_op;
      c_bit = '0;
      grp_g = '0;
      grp_p = '1;
      cg    = '0;
      cg[0] = sub;
      for (int i = 0; i < (NG - 1) * GS; i++) begin
         grp_g[i/GS] = g[i] | (p[i] & grp_g[i/GS]);
         grp_p[i/GS] = grp_p[i/GS] & p[i];
      end
      for (int j = 0; j < NG - 1; j++) begin
         cg[j+1] = grp_g[j] | (grp_p[j] & cg[j]);
      end
      for (int i = 0; i < DIV_RW; i++) begin
         if (i % GS == 0) begin
            c_bit[i] = cg[i/GS];
         end else begin
            c_bit[i] = g[i-1] | (p[i-1] & c_bit[i-1]);
         end
      end
      sum = p ^ c_bit;
   end

   assign r_out = sum;
   assign q_bit = ~sum[DIV_RW-1];

endmodule

// File: rtl/div_tc_32_16.sv
// Sequential 32/16 signed divider, one quotient bit per cycle behind a start/done handshake.
//   state   | meaning
//   IDLE    | waiting for start; operands latched on acceptance
//   CALC    | 32 non-restoring iterations on the magnitudes
//   FIX     | remainder correction, sign application, special cases; results registered
//   DONE    | done pulse for one cycle
module div_tc_32_16
   import div_tc_pkg::*;
#(
   parameter int DW = DIV_DW,
   parameter int VW = DIV_VW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          dbz,
   output logic          ovf
);

   div_state_t               state;
   div_state_t               state_nxt;
   logic [4:0]               cnt;
   logic signed [DIV_RW-1:0] r_q;
   logic signed [DIV_RW-1:0] r_nxt;
   logic [VW-1:0]            d_q;
   logic [DW-1:0]            a_q;
   logic [DW-1:0]            dvd_q;
   logic                     neg_n;
   logic                     neg_d;
   logic                     dvs_m1;
   logic                     dbz_sel;
   logic                     q_bit;
   logic                     accept;
   logic                     ovf_case;
   logic [VW-1:0]            rem_mag;
   logic [DW-1:0]            q_signed;
   logic [VW-1:0]            rem_signed;

   assign accept = (state == ST_IDLE) && start;

   div_nr_step u_step (
      .r_in   (r_q),
      .d_in   (d_q),
      .bit_in (a_q[DW-1]),
      .r_out  (r_nxt),
      .q_bit  (q_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = (divisor == '0) ? ST_FIX : ST_CALC;
         ST_CALC: if (cnt == 5'(DIV_ITER - 1)) state_nxt = ST_FIX;
         ST_FIX:  state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state != ST_IDLE);
      done = (state == ST_DONE);
   end

   // a_q shifts dividend magnitude bits out of the top while quotient bits enter at the bottom.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         r_q     <= '0;
         d_q     <= '0;
         a_q     <= '0;
         dvd_q   <= '0;
         neg_n   <= 1'b0;
         neg_d   <= 1'b0;
         dvs_m1  <= 1'b0;
         dbz_sel <= 1'b0;
      end else if (accept) begin
         cnt     <= '0;
         r_q     <= '0;
         d_q     <= divisor[VW-1] ? (~divisor + 1'b1) : divisor;
         a_q     <= abs_u(dividend);
         dvd_q   <= dividend;
         neg_n   <= dividend[DW-1];
         neg_d   <= divisor[VW-1];
         dvs_m1  <= (divisor == '1);
         dbz_sel <= (divisor == '0);
      end else if (state == ST_CALC) begin
         cnt <= cnt + 5'd1;
         r_q <= r_nxt;
         a_q <= {a_q[DW-2:0], q_bit};
      end
   end

   assign ovf_case   = dvs_m1 && (dvd_q == {1'b1, {(DW-1){1'b0}}});
   assign rem_mag    = r_q[DIV_RW-1] ? (r_q[VW-1:0] + d_q) : r_q[VW-1:0];
   assign q_signed   = (neg_n ^ neg_d) ? (~a_q + 1'b1) : a_q;
   assign rem_signed = neg_n ? (~rem_mag + 1'b1) : rem_mag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quotient  <= '0;
         remainder <= '0;
         dbz       <= 1'b0;
         ovf       <= 1'b0;
      end else if (state == ST_FIX) begin
         if (dbz_sel) begin
            quotient  <= '1;
            remainder <= dvd_q[VW-1:0];
            dbz       <= 1'b1;
            ovf       <= 1'b0;
         end else if (ovf_case) begin
            quotient  <= {1'b1, {(DW-1){1'b0}}};
            remainder <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b1;
         end else begin
            quotient  <= q_signed;
            remainder <= rem_signed;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
         end
      end
   end

endmodule
